// File: rtl/maria_regfile_pkg.sv
// maria_regfile_pkg: register offsets, WSYNC state type and colour index mapping
package maria_regfile_pkg;

    localparam logic [4:0] OFS_BACKGRND = 5'h00;
    localparam logic [4:0] OFS_WSYNC    = 5'h04;
    localparam logic [4:0] OFS_MSTAT    = 5'h08;
    localparam logic [4:0] OFS_DPPH     = 5'h0C;
    localparam logic [4:0] OFS_DPPL     = 5'h10;
    localparam logic [4:0] OFS_CHARBASE = 5'h14;
    localparam logic [4:0] OFS_CTRL     = 5'h1C;

    typedef enum logic {WS_IDLE, WS_WAIT} wsync_state_e;

    // Offset 4p+1+c maps to colour slot 1+3p+c; anything with low bits 00 maps to slot 0
    function automatic logic [4:0] colour_index(input logic [4:0] ofs);
        return (ofs[1:0] == 2'd0) ? 5'd0 : 5'd3 * {2'b0, ofs[4:2]} + {3'b0, ofs[1:0]};
    endfunction

endpackage

// File: rtl/maria_wsync_ctl.sv
// maria_wsync_ctl: holds the CPU off (ready low) from a WSYNC write until the next line start
module maria_wsync_ctl
    import maria_regfile_pkg::*;
(
    input  logic sysclock,
    input  logic reset,
    input  logic wsync_wr,
    input  logic hblank_start,
    output logic ready
);

    wsync_state_e state, state_nx;

    // State register
    always_ff @(posedge sysclock) begin
        if (reset) state <= WS_IDLE;
        else       state <= state_nx;
    end

    // A line start only counts once already waiting, so one coincident with the write is ignored
    always_comb begin
        state_nx = (state == WS_IDLE) ? (wsync_wr ? WS_WAIT : WS_IDLE)
                                      : (hblank_start ? WS_IDLE : WS_WAIT);
        ready    = (state == WS_IDLE);
    end

endmodule

// File: rtl/maria_regfile.sv
// maria_regfile: CPU-visible display register window (colours, pointer staging, control, WSYNC)
module maria_regfile
    import maria_regfile_pkg::*;
#(
    parameter int         NUM_PALETTES = 8,
    parameter logic [7:0] OPEN_BUS     = 8'hBE,
    parameter logic [7:0] CTRL_RST     = 8'h40,
    parameter logic [15:0] ZP_RST      = 16'h1820
) (
    input  logic                          sysclock,
    input  logic                          reset,
    input  logic                          bus_en,
    input  logic                          sel,
    input  logic                          we_b,
    input  logic [4:0]                    addr,
    input  logic [7:0]                    db_in,
    output logic [7:0]                    db_out,
    input  logic [7:0]                    status_in,
    input  logic                          hblank_start,
    input  logic                          vblank_end,
    output logic [7:0]                    ctrl,
    output logic [7:0]                    char_base,
    output logic [15:0]                   zp,
    output logic                          zp_written,
    output logic [8*(1+3*NUM_PALETTES)-1:0] color_map,
    output logic                          ready
);

    localparam int NCOL = 1 + 3 * NUM_PALETTES;

    logic       wr, rd, pal_ok, col_hit;
    logic [4:0] cidx;
    logic [7:0] colors [NCOL];
    logic [7:0] rd_col, rd_val;
    logic [15:0] stg;
    logic       hi_w, lo_w;

    assign wr      = bus_en & sel & ~we_b;
    assign rd      = bus_en & sel & we_b;
    assign cidx    = colour_index(addr);
    assign pal_ok  = int'(addr[4:2]) < NUM_PALETTES;
    assign col_hit = (addr == OFS_BACKGRND) || (addr[1:0] != 2'd0 && pal_ok);

    for (genvar g = 0; g < NCOL; g++) begin : g_map
        assign color_map[8*g +: 8] = colors[g];
    end

    // Read mux: staged pointer bytes, live status, otherwise open bus
    always_comb begin
        rd_col = OPEN_BUS;
        for (int i = 0; i < NCOL; i++) if (cidx == 5'(i)) rd_col = colors[i];
        rd_val = col_hit                 ? rd_col           :
                 addr == OFS_MSTAT       ? status_in        :
                 addr == OFS_DPPH        ? stg[15:8]        :
                 addr == OFS_DPPL        ? stg[7:0]         :
                 addr == OFS_CHARBASE    ? char_base        :
                 addr == OFS_CTRL        ? ctrl             : OPEN_BUS;
    end

    // Colour, CHARBASE and CTRL registers
    always_ff @(posedge sysclock) begin
        if (reset) begin
            ctrl      <= CTRL_RST;
            char_base <= 8'h00;
            for (int i = 0; i < NCOL; i++) colors[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NCOL; i++) if (wr && col_hit && cidx == 5'(i)) colors[i] <= db_in;
            if (wr && addr == OFS_CHARBASE) char_base <= db_in;
            if (wr && addr == OFS_CTRL)     ctrl      <= db_in;
        end
    end

    // Pointer staging; a same-cycle byte write lands after the commit so it survives
    always_ff @(posedge sysclock) begin
        if (reset) begin
            zp         <= ZP_RST;
            stg        <= ZP_RST;
            hi_w       <= 1'b0;
            lo_w       <= 1'b0;
            zp_written <= 1'b0;
        end else begin
            zp_written <= 1'b0;
            if (vblank_end && hi_w && lo_w) begin
                zp         <= stg;
                hi_w       <= 1'b0;
                lo_w       <= 1'b0;
                zp_written <= 1'b1;
            end
            if (wr && addr == OFS_DPPH) begin
                stg[15:8] <= db_in;
                hi_w      <= 1'b1;
            end
            if (wr && addr == OFS_DPPL) begin
                stg[7:0] <= db_in;
                lo_w     <= 1'b1;
            end
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge sysclock) begin
        if (reset)   db_out <= OPEN_BUS;
        else if (rd) db_out <= rd_val;
    end

    maria_wsync_ctl u_wsync (
        .sysclock     (sysclock),
        .reset        (reset),
        .wsync_wr     (wr && addr == OFS_WSYNC),
        .hblank_start (hblank_start),
        .ready        (ready)
    );

endmodule

// File: doc/maria_regfile.md
MARIA_REGFILE -- requirements
Module: maria_regfile

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- NUM_PALETTES, 8, implemented palettes, legal range 1..8.
- OPEN_BUS, 8'hBE, read data for unmapped or unimplemented offsets.
- CTRL_RST, 8'h40, reset value of CTRL.
- ZP_RST, 16'h1820, reset value of the live and staged display-list pointer.

REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- sysclock, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- bus_en, in, 1, one-sysclock strobe per CPU bus cycle (pclk_0 edge).
- sel, in, 1, register window selected (decode is done outside this block).
- we_b, in, 1, 0 = write, 1 = read.
- addr, in, 5, offset within the 32-byte window (0x00 = BACKGRND).
- db_in, in, 8, write data.
- db_out, out, 8, registered read data.
- status_in, in, 8, MSTAT source.
- hblank_start, in, 1, one-cycle pulse at the start of each line.
- vblank_end, in, 1, one-cycle pulse at the first visible line.
- ctrl, out, 8, CTRL register.
- char_base, out, 8, CHARBASE register.
- zp, out, 16, live display-list-list pointer.
- zp_written, out, 1, one-cycle pulse when a staged pointer is committed.
- color_map, out, 8*(1+3*NUM_PALETTES), background followed by palette colours, palette-major.
- ready, out, 1, CPU ready; low while a WSYNC is pending.

Function
REQ-003 An access SHALL occur only when bus_en=1 and sel=1; all other cycles SHALL leave register state unchanged.
REQ-004 Offset map: 0x00 = BACKGRND; 4p+1+c (p=0..7, c=0..2) = palette p colour c; 0x04 = WSYNC; 0x08 = MSTAT; 0x0C = DPPH; 0x10 = DPPL; 0x14 = CHARBASE; 0x18 = unused; 0x1C = CTRL.
REQ-005 Writes to palette p >= NUM_PALETTES SHALL be ignored, and reads of those offsets SHALL return OPEN_BUS.
REQ-006 Colour, CHARBASE and CTRL writes SHALL take effect on the outputs one sysclock after the strobe cycle.
REQ-007 Read latency SHALL be one sysclock.
- db_out holds the addressed value (MSTAT = status_in, sampled in the strobe cycle).
- Unused, unimplemented and WSYNC offsets return OPEN_BUS.
- db_out holds its value between reads.
REQ-008 Reads of DPPH and DPPL SHALL return the staged bytes, not the live zp.
REQ-009 Writes to DPPH and DPPL SHALL update the staged bytes and set the per-byte flags hi_w and lo_w.
REQ-010 On vblank_end with hi_w&lo_w=1, the block SHALL do all of the following in one cycle:
- copy the staged bytes to zp;
- clear both flags;
- pulse zp_written for exactly one cycle.
REQ-011 On vblank_end with only one flag set, zp SHALL be left unchanged and the flags SHALL be kept.
REQ-012 If a DPPx write and vblank_end fall in the same cycle, the commit SHALL use the pre-write staged value and flags, and the written byte SHALL be staged with its flag set afterwards.
REQ-013 WSYNC SHALL be a two-state FSM, IDLE and WAIT.
- A WSYNC write in IDLE SHALL move to WAIT, with ready low from the next cycle.
- WAIT SHALL return to IDLE on the first hblank_start strictly after the write cycle, with ready high from the next cycle.
- An hblank_start coincident with the write SHALL be ignored.
- A WSYNC write in WAIT SHALL not change state.
REQ-014 ready SHALL be 1 only in IDLE.

Reset
REQ-015 With reset=1 at a sysclock edge, the block SHALL set:
- ctrl = CTRL_RST, char_base = 0, color_map = all 0;
- zp = staged = ZP_RST, flags = 0, zp_written = 0;
- db_out = OPEN_BUS, FSM = IDLE, ready = 1.
REQ-016 Reset SHALL take priority over every strobe, and a pending WSYNC or partial pointer write SHALL be discarded.

Structure
REQ-017 A shared package SHALL hold:
- the offset constants (OFS_BACKGRND, OFS_WSYNC, OFS_MSTAT, OFS_DPPH, OFS_DPPL, OFS_CHARBASE, OFS_CTRL);
- the WSYNC state enum;
- the function that maps an offset to a palette/colour index.
REQ-018 The WSYNC FSM SHALL be one sub-module, maria_wsync_ctl; all other logic stays in maria_regfile.

Verification
REQ-019 Write 8'h32 to 0x01, then read 0x01: color_map[1] = 8'h32 one cycle after the strobe, and db_out = 8'h32 one cycle after the read strobe.
REQ-020 NUM_PALETTES=5: write 8'hAA to 0x1D, then read 0x1D: color_map unchanged and db_out = 8'hBE; a read of 0x18 also returns 8'hBE.
REQ-021 Write DPPH=8'h20 and DPPL=8'h00, then pulse vblank_end: zp = 16'h2000 and zp_written high for exactly one cycle.
REQ-022 Write DPPH only, then vblank_end: zp stays at 16'h1820; a later DPPL write plus vblank_end commits the new zp.
REQ-023 WSYNC write with hblank_start in the same cycle: ready low, unaffected by that pulse, and high again one cycle after the next hblank_start.
REQ-024 Assert reset while in WAIT with hi_w set: ready = 1, zp = 16'h1820, and a following vblank_end produces no zp_written.
